cvxif_offload_unit: RTL and testbench

CVXIF_OFFLOAD_UNIT -- requirements
Module: cvxif_offload_unit

---
 rtl/config_pkg.sv | 10 +
 rtl/cvxif_pkg.sv | 85 ++++++++
 rtl/cvxif_id_table.sv | 67 ++++++
 rtl/cvxif_offload_unit.sv | 144 ++++++++++++++
 tb/tb_cvxif_offload_unit.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/config_pkg.sv
// Core configuration record: only the fields the offload unit consumes.
package config_pkg;

  typedef struct packed {
    int unsigned XLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32'd32};

endpackage

// File: rtl/cvxif_pkg.sv
// CV-X-IF request/response types, offload table entry and offload FSM states.
package cvxif_pkg;

  localparam int unsigned X_ID_WIDTH  = 4;
  localparam int unsigned X_RFR_WIDTH = 32;
  localparam int unsigned X_NUM_RS    = 2;

  typedef logic [X_ID_WIDTH-1:0] x_id_t;

  // One entry per instruction id; busy marks an accepted, unfinished instruction.
  typedef struct packed {
    logic       busy;
    logic [4:0] rd;
    logic       we;
  } offload_entry_t;

  typedef enum logic {
    IDLE,
    ISSUE
  } offload_state_e;

  typedef struct packed {
    logic [15:0] instr;
    x_id_t       id;
  } x_compressed_req_t;

  typedef struct packed {
    logic [31:0]                            instr;
    x_id_t                                  id;
    logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0]   rs;
    logic [X_NUM_RS-1:0]                    rs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
  } x_issue_resp_t;

  typedef struct packed {
    x_id_t id;
    logic  commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic       exc;
    logic [5:0] exccode;
  } x_mem_resp_t;

  typedef struct packed {
    x_id_t                  id;
    logic [X_RFR_WIDTH-1:0] rdata;
    logic                   err;
  } x_mem_result_t;

  typedef struct packed {
    x_id_t                  id;
    logic [X_RFR_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
  } x_result_t;

  typedef struct packed {
    logic              x_compressed_valid;
    x_compressed_req_t x_compressed_req;
    logic              x_issue_valid;
    x_issue_req_t      x_issue_req;
    logic              x_commit_valid;
    x_commit_t         x_commit;
    logic              x_mem_ready;
    x_mem_resp_t       x_mem_resp;
    logic              x_mem_result_valid;
    x_mem_result_t     x_mem_result;
    logic              x_result_ready;
  } cvxif_req_t;

  typedef struct packed {
    logic          x_compressed_ready;
    logic          x_issue_ready;
    x_issue_resp_t x_issue_resp;
    logic          x_mem_valid;
    logic          x_result_valid;
    x_result_t     x_result;
  } cvxif_resp_t;

endpackage

// File: rtl/cvxif_id_table.sv
// Id-indexed table of outstanding offloaded instructions with an occupancy count.
// A set and a clear in the same cycle both apply; on equal ids the set wins.
module cvxif_id_table
  import cvxif_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            set_i,
  input  x_id_t           set_id_i,
  input  logic [4:0]      set_rd_i,
  input  logic            set_we_i,
  input  logic            clr_i,
  input  x_id_t           clr_id_i,
  input  x_id_t           lookup_id_i,
  output offload_entry_t  lookup_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned Depth = 1 << X_ID_WIDTH;

  logic [Depth-1:0] busy_q;
  logic [4:0]       rd_q [Depth];
  logic             we_q [Depth];
  logic [CntW-1:0]  count_q;
  logic             clr_hit;

  // Only a clear of a busy entry retires an instruction.
  assign clr_hit = clr_i && busy_q[clr_id_i];

  // Busy bits: clear first, then set so a same-id accept overrides the clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      if (clr_hit) busy_q[clr_id_i] <= 1'b0;
      if (set_i)   busy_q[set_id_i] <= 1'b1;
    end
  end

  // Destination payload is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (set_i) begin
      rd_q[set_id_i] <= set_rd_i;
      we_q[set_id_i] <= set_we_i;
    end
  end

  // Occupancy count, saturating at both ends.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      case ({set_i, clr_hit})
        2'b10: if (count_q != CntW'(MaxOutstanding)) count_q <= count_q + 1'b1;
        2'b01: if (count_q != '0) count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign lookup_o = '{busy: busy_q[lookup_id_i], rd: rd_q[lookup_id_i], we: we_q[lookup_id_i]};
  assign count_o  = count_q;

endmodule

// File: rtl/cvxif_offload_unit.sv
// Offloads core instructions to a CV-X-IF coprocessor and routes results back.
//
// state | meaning
// IDLE  | waiting for an instruction; ready while the table has room
// ISSUE | buffered instruction presented on x_issue until the coprocessor takes it
module cvxif_offload_unit
  import cvxif_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg        = config_pkg::cva6_cfg_empty,
  parameter int unsigned           MaxOutstanding = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    instr_valid_i,
  output logic                    instr_ready_o,
  input  logic [31:0]             instr_i,
  input  logic [CVA6Cfg.XLEN-1:0] rs1_i,
  input  logic [CVA6Cfg.XLEN-1:0] rs2_i,
  input  x_id_t                   id_i,
  output cvxif_req_t              cvxif_req_o,
  input  cvxif_resp_t             cvxif_resp_i,
  output logic                    wb_valid_o,
  input  logic                    wb_ready_i,
  output x_id_t                   wb_id_o,
  output logic [4:0]              wb_rd_o,
  output logic [CVA6Cfg.XLEN-1:0] wb_data_o,
  output logic                    wb_we_o,
  output logic                    illegal_valid_o,
  output x_id_t                   illegal_id_o,
  output logic                    protocol_err_o
);

  localparam int unsigned XLEN = CVA6Cfg.XLEN;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  offload_state_e  state_q, state_d;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] rs1_q, rs2_q;
  x_id_t           id_q;
  logic            capture, issue_hs, accept_set, result_hs;
  logic            illegal_q;
  x_id_t           illegal_id_q;
  logic            protocol_err_q;
  offload_entry_t  entry;
  logic [CntW-1:0] count;
  logic            unused_resp;

  assign unused_resp = ^{cvxif_resp_i.x_compressed_ready, cvxif_resp_i.x_mem_valid,
                         cvxif_resp_i.x_result.rd};

  // Next state, issue request and core-side ready.
  always_comb begin
    state_d       = state_q;
    cvxif_req_o   = '0;
    instr_ready_o = 1'b0;
    capture       = 1'b0;
    issue_hs      = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready_o = (count < CntW'(MaxOutstanding));
        if (instr_valid_i && instr_ready_o) begin
          capture = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cvxif_req_o.x_issue_valid           = 1'b1;
        cvxif_req_o.x_issue_req.instr       = instr_q;
        cvxif_req_o.x_issue_req.id          = id_q;
        cvxif_req_o.x_issue_req.rs[0]       = X_RFR_WIDTH'(rs1_q);
        cvxif_req_o.x_issue_req.rs[1]       = X_RFR_WIDTH'(rs2_q);
        cvxif_req_o.x_issue_req.rs_valid    = '1;
        if (cvxif_resp_i.x_issue_ready) begin
          issue_hs = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    cvxif_req_o.x_result_ready = wb_ready_i;
  end

  assign accept_set = issue_hs && cvxif_resp_i.x_issue_resp.accept;
  assign result_hs  = cvxif_resp_i.x_result_valid && wb_ready_i;

  cvxif_id_table #(
    .MaxOutstanding(MaxOutstanding)
  ) u_id_table (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .set_i      (accept_set),
    .set_id_i   (id_q),
    .set_rd_i   (instr_q[11:7]),
    .set_we_i   (cvxif_resp_i.x_issue_resp.writeback),
    .clr_i      (result_hs),
    .clr_id_i   (cvxif_resp_i.x_result.id),
    .lookup_id_i(cvxif_resp_i.x_result.id),
    .lookup_o   (entry),
    .count_o    (count)
  );

  // State register; reset drops issue_valid immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Issue buffer, loaded on the core handshake.
  always_ff @(posedge clk_i) begin
    if (capture) begin
      instr_q <= instr_i;
      rs1_q   <= rs1_i;
      rs2_q   <= rs2_i;
      id_q    <= id_i;
    end
  end

  // One-cycle illegal pulse for a rejected issue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      illegal_q    <= 1'b0;
      illegal_id_q <= '0;
    end else begin
      illegal_q <= issue_hs && !cvxif_resp_i.x_issue_resp.accept;
      if (issue_hs) illegal_id_q <= id_q;
    end
  end

  // Sticky error for a result whose id is not outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                      protocol_err_q <= 1'b0;
    else if (result_hs && !entry.busy) protocol_err_q <= 1'b1;
  end

  assign wb_valid_o      = cvxif_resp_i.x_result_valid;
  assign wb_id_o         = cvxif_resp_i.x_result.id;
  assign wb_data_o       = XLEN'(cvxif_resp_i.x_result.data);
  assign wb_rd_o         = entry.rd;
  assign wb_we_o         = cvxif_resp_i.x_result.we && entry.we;
  assign illegal_valid_o = illegal_q;
  assign illegal_id_o    = illegal_id_q;
  assign protocol_err_o  = protocol_err_q;

endmodule

// File: tb/tb_cvxif_offload_unit.sv
// Directed bench for cvxif_offload_unit.
module tb_cvxif_offload_unit;
  import cvxif_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr, rs1, rs2;
  x_id_t       id;
  cvxif_req_t  req;
  cvxif_resp_t resp;
  logic        wb_valid, wb_ready, wb_we;
  x_id_t       wb_id, illegal_id;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal_valid, protocol_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cvxif_offload_unit #(.MaxOutstanding(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .instr_valid_i  (instr_valid),
    .instr_ready_o  (instr_ready),
    .instr_i        (instr),
    .rs1_i          (rs1),
    .rs2_i          (rs2),
    .id_i           (id),
    .cvxif_req_o    (req),
    .cvxif_resp_i   (resp),
    .wb_valid_o     (wb_valid),
    .wb_ready_i     (wb_ready),
    .wb_id_o        (wb_id),
    .wb_rd_o        (wb_rd),
    .wb_data_o      (wb_data),
    .wb_we_o        (wb_we),
    .illegal_valid_o(illegal_valid),
    .illegal_id_o   (illegal_id),
    .protocol_err_o (protocol_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single cycle; leaves the DUT in ISSUE.
  task automatic launch(input x_id_t i, input logic [31:0] w, input logic [31:0] a,
                        input logic [31:0] b);
    instr_valid = 1'b1;
    instr       = w;
    rs1         = a;
    rs2         = b;
    id          = i;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic result(input x_id_t i, input logic [31:0] d, input logic we);
    resp.x_result_valid = 1'b1;
    resp.x_result.id    = i;
    resp.x_result.data  = d;
    resp.x_result.rd    = 5'd0;
    resp.x_result.we    = we;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    rs1         = '0;
    rs2         = '0;
    id          = '0;
    resp        = '0;
    wb_ready    = 1'b0;

    // reset
    #12;
    check("rst_issue_valid", 64'(req.x_issue_valid), 64'd0);
    check("rst_illegal", 64'(illegal_valid), 64'd0);
    check("rst_perr", 64'(protocol_err), 64'd0);
    check("rst_count", 64'(dut.u_id_table.count_o), 64'd0);
    check("rst_busy", 64'(dut.u_id_table.busy_q), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    check("rst_ready", 64'(instr_ready), 64'd1);

    // single accept: id 3, rd x5
    resp.x_issue_ready          = 1'b1;
    resp.x_issue_resp.accept    = 1'b1;
    resp.x_issue_resp.writeback = 1'b1;
    instr_valid = 1'b1;
    instr = 32'h00C5_828B;
    rs1   = 32'h11;
    rs2   = 32'h22;
    id    = 4'd3;
    #1 check("t1_ready_idle", 64'(instr_ready), 64'd1);
    tick();
    instr_valid = 1'b0;
    check("t1_issue_valid", 64'(req.x_issue_valid), 64'd1);
    check("t1_issue_id", 64'(req.x_issue_req.id), 64'd3);
    check("t1_issue_instr", 64'(req.x_issue_req.instr), 64'h00C5_828B);
    check("t1_rs1", 64'(req.x_issue_req.rs[0]), 64'h11);
    check("t1_rs2", 64'(req.x_issue_req.rs[1]), 64'h22);
    check("t1_rs_valid", 64'(req.x_issue_req.rs_valid), 64'h3);
    check("t1_ready_issue", 64'(instr_ready), 64'd0);
    check("t1_commit_valid", 64'(req.x_commit_valid), 64'd0);
    tick();
    check("t1_issue_done", 64'(req.x_issue_valid), 64'd0);
    check("t1_count1", 64'(dut.u_id_table.count_o), 64'd1);
    check("t1_busy3", 64'(dut.u_id_table.busy_q[3]), 64'd1);
    result(4'd3, 32'h1234, 1'b1);
    wb_ready = 1'b1;
    #1;
    check("t1_wb_valid", 64'(wb_valid), 64'd1);
    check("t1_wb_id", 64'(wb_id), 64'd3);
    check("t1_wb_rd", 64'(wb_rd), 64'd5);
    check("t1_wb_data", 64'(wb_data), 64'h1234);
    check("t1_wb_we", 64'(wb_we), 64'd1);
    check("t1_result_ready", 64'(req.x_result_ready), 64'd1);
    tick();
    resp.x_result_valid = 1'b0;
    check("t1_count0", 64'(dut.u_id_table.count_o), 64'd0);
    check("t1_perr", 64'(protocol_err), 64'd0);

    // reject: id 7
    resp.x_issue_resp.accept = 1'b0;
    launch(4'd7, 32'h0000_038B, 32'h1, 32'h2);
    check("t2_no_early_illegal", 64'(illegal_valid), 64'd0);
    tick();
    check("t2_illegal", 64'(illegal_valid), 64'd1);
    check("t2_illegal_id", 64'(illegal_id), 64'd7);
    check("t2_count", 64'(dut.u_id_table.count_o), 64'd0);
    check("t2_no_wb", 64'(wb_valid), 64'd0);
    tick();
    check("t2_illegal_end", 64'(illegal_valid), 64'd0);

    // backpressure: 5 stalled cycles, id 4, rd x12, writeback=0
    resp.x_issue_ready          = 1'b0;
    resp.x_issue_resp.accept    = 1'b1;
    resp.x_issue_resp.writeback = 1'b0;
    launch(4'd4, 32'h0006_360B, 32'hA5A5_0001, 32'h5A5A_0002);
    instr_valid = 1'b1;
    instr = 32'hDEAD_BEEF;
    rs1   = 32'hFFFF_FFFF;
    id    = 4'd5;
    for (int k = 0; k < 5; k++) begin
      check("t3_hold_valid", 64'(req.x_issue_valid), 64'd1);
      check("t3_hold_instr", 64'(req.x_issue_req.instr), 64'h0006_360B);
      check("t3_hold_id", 64'(req.x_issue_req.id), 64'd4);
      check("t3_hold_rs1", 64'(req.x_issue_req.rs[0]), 64'hA5A5_0001);
      check("t3_hold_ready", 64'(instr_ready), 64'd0);
      tick();
    end
    instr_valid = 1'b0;
    resp.x_issue_ready = 1'b1;
    tick();
    check("t3_issue_done", 64'(req.x_issue_valid), 64'd0);
    check("t3_count1", 64'(dut.u_id_table.count_o), 64'd1);
    result(4'd4, 32'hBEEF, 1'b1);
    #1;
    check("t3_wb_rd", 64'(wb_rd), 64'd12);
    check("t3_wb_we_masked", 64'(wb_we), 64'd0);
    tick();
    resp.x_result_valid = 1'b0;
    check("t3_count0", 64'(dut.u_id_table.count_o), 64'd0);

    // full: ids 0..3 accepted
    resp.x_issue_resp.writeback = 1'b1;
    for (int i = 0; i < 4; i++) begin
      launch(x_id_t'(i), {20'h0, 5'(i + 8), 7'h0B}, 32'(i), 32'(i));
      tick();
    end
    check("t4_count4", 64'(dut.u_id_table.count_o), 64'd4);
    check("t4_ready_full", 64'(instr_ready), 64'd0);
    instr_valid = 1'b1;
    id = 4'd5;
    tick();
    check("t4_not_taken", 64'(req.x_issue_valid), 64'd0);
    instr_valid = 1'b0;
    result(4'd0, 32'h0, 1'b1);
    #1;
    check("t4_wb_rd0", 64'(wb_rd), 64'd8);
    check("t4_ready_same_cycle", 64'(instr_ready), 64'd0);
    tick();
    resp.x_result_valid = 1'b0;
    check("t4_ready_after", 64'(instr_ready), 64'd1);
    check("t4_count3", 64'(dut.u_id_table.count_o), 64'd3);

    // simultaneous accept id 2 with result id 1
    result(4'd2, 32'h2, 1'b1);
    tick();
    result(4'd3, 32'h3, 1'b1);
    tick();
    resp.x_result_valid = 1'b0;
    check("t5_count1", 64'(dut.u_id_table.count_o), 64'd1);
    launch(4'd2, 32'h0000_048B, 32'h7, 32'h8);
    result(4'd1, 32'h1, 1'b1);
    tick();
    resp.x_result_valid = 1'b0;
    check("t5_count_same", 64'(dut.u_id_table.count_o), 64'd1);
    check("t5_busy1", 64'(dut.u_id_table.busy_q[1]), 64'd0);
    check("t5_busy2", 64'(dut.u_id_table.busy_q[2]), 64'd1);
    result(4'd2, 32'h22, 1'b1);
    #1 check("t5_wb_rd2", 64'(wb_rd), 64'd9);
    tick();
    resp.x_result_valid = 1'b0;
    check("t5_count0", 64'(dut.u_id_table.count_o), 64'd0);
    check("t5_perr", 64'(protocol_err), 64'd0);

    // spurious result id 9
    result(4'd9, 32'h99, 1'b1);
    #1;
    check("t6_wb_forward", 64'(wb_valid), 64'd1);
    check("t6_wb_id", 64'(wb_id), 64'd9);
    check("t6_perr_before", 64'(protocol_err), 64'd0);
    tick();
    resp.x_result_valid = 1'b0;
    check("t6_perr", 64'(protocol_err), 64'd1);
    check("t6_count", 64'(dut.u_id_table.count_o), 64'd0);
    tick();
    tick();
    check("t6_perr_sticky", 64'(protocol_err), 64'd1);

    // reset while in ISSUE
    resp.x_issue_ready = 1'b0;
    launch(4'd6, 32'h0000_030B, 32'h3, 32'h4);
    check("t7_in_issue", 64'(req.x_issue_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_async_drop", 64'(req.x_issue_valid), 64'd0);
    check("t7_perr_clr", 64'(protocol_err), 64'd0);
    check("t7_illegal", 64'(illegal_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    resp.x_issue_ready = 1'b1;
    resp.x_issue_resp.accept = 1'b0;
    tick();
    check("t7_no_illegal", 64'(illegal_valid), 64'd0);
    check("t7_idle", 64'(req.x_issue_valid), 64'd0);
    check("t7_ready", 64'(instr_ready), 64'd1);
    check("t7_count", 64'(dut.u_id_table.count_o), 64'd0);
    tick();
    check("t7_no_illegal2", 64'(illegal_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
